// File: rtl/strhw_common_types.sv
// -----------------------------------------------------------------------------
// strhw_common_types
// Shared types and constants for the Streebog hardware blocks.
//   state_t        : core status reported on the core's state port
//   sched_state_t  : stream scheduler FSM states
//   uint64         : one 64-bit message word
//   sat_bytes()    : clamps a final-word byte count to the word size
//   byte_mask()    : per-byte keep mask for a partially valid final word
// -----------------------------------------------------------------------------
package strhw_common_types;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      READY = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      FILL    = 3'd0,
      LAUNCH  = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      OUT     = 3'd4
   } sched_state_t;

   localparam int STRHW_BLOCK_BYTES = 64;
   localparam int STRHW_WORD_BYTES  = 8;

   typedef logic [63:0] uint64;

   function automatic logic [3:0] sat_bytes(input logic [3:0] n);
      return (n > 4'(STRHW_WORD_BYTES)) ? 4'(STRHW_WORD_BYTES) : n;
   endfunction

   function automatic uint64 byte_mask(input logic [3:0] n);
      uint64 m;
      m = 64'd0;
      for (int i = 0; i < STRHW_WORD_BYTES; i++) begin
         m[8*i +: 8] = (4'(i) < n) ? 8'hFF : 8'h00;
      end
      return m;
   endfunction

endpackage

// File: rtl/strhw_word_packer.sv
// -----------------------------------------------------------------------------
// strhw_word_packer
// Packs 64-bit message words into a 512-bit block buffer and computes the
// block size in bytes for the word currently presented.
//   clk_i, rst_i  : clock, synchronous active-low reset
//   wr_i          : write the presented word into slot word_cnt
//   clr_i         : clear buffer and word count (start of a new block)
//   data_i        : message word, byte 0 in bits [7:0]
//   last_i        : presented word is the last of the message
//   bytes_i       : valid bytes in the last word (saturated to 8)
//   word_cnt_o    : number of words already held
//   block_o       : buffer with the presented word merged in (combinational)
//   size_o        : block size if the presented word closes the block
// -----------------------------------------------------------------------------
module strhw_word_packer
   import strhw_common_types::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         wr_i,
   input  logic         clr_i,
   input  uint64        data_i,
   input  logic         last_i,
   input  logic [3:0]   bytes_i,
   output logic [2:0]   word_cnt_o,
   output logic [511:0] block_o,
   output logic [6:0]   size_o
);

   logic [511:0] buffer_r;
   logic [2:0]   word_cnt_r;
   uint64        word_s;
   logic [3:0]   bytes_sat_s;

   // Merge the masked incoming word into its slot and derive the block size.
   always_comb begin
      bytes_sat_s = sat_bytes(bytes_i);
      if (last_i) begin
         word_s = data_i & byte_mask(bytes_sat_s);
         size_o = {1'b0, word_cnt_r, 3'b000} + {3'b000, bytes_sat_s};
      end else begin
         word_s = data_i;
         size_o = 7'(STRHW_BLOCK_BYTES);
      end
      block_o = buffer_r;
      block_o[{word_cnt_r, 6'd0} +: 64] = word_s;
   end

   // Buffer and word counter; the counter holds at 7 until the block is cleared.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         buffer_r   <= 512'd0;
         word_cnt_r <= 3'd0;
      end else if (clr_i) begin
         buffer_r   <= 512'd0;
         word_cnt_r <= 3'd0;
      end else if (wr_i) begin
         buffer_r <= block_o;
         if (word_cnt_r != 3'd7) begin
            word_cnt_r <= word_cnt_r + 3'd1;
         end
      end
   end

   assign word_cnt_o = word_cnt_r;

endmodule

// File: rtl/strhw_stream_sched.sv
// -----------------------------------------------------------------------------
// strhw_stream_sched
// Front-end scheduler for the Streebog core: accepts 64-bit message words,
// packs them into 512-bit blocks, triggers the core once per block (including
// the mandatory final short/empty block) and holds the final hash.
//   s_valid_i/s_ready_o/s_data_i/s_last_i/s_bytes_i : message word stream
//   hash_size_i       : 0=512-bit, 1=256-bit, taken on first word of a message
//   core_trg_o        : one-cycle start pulse; core_block_o/_size_o stable
//                       from the pulse until the next one
//   core_state_i      : core status, READY when the core is done
//   core_hash_i       : core hash result
//   hash_valid_o/hash_ready_i/hash_o : registered hash output handshake
//   busy_o            : a message is open
// -----------------------------------------------------------------------------
module strhw_stream_sched
   import strhw_common_types::*;
#(
   parameter int WORD_W    = 64,
   parameter int GUARD_CYC = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [WORD_W-1:0] s_data_i,
   input  logic              s_last_i,
   input  logic [3:0]        s_bytes_i,
   input  logic              hash_size_i,
   output logic              core_trg_o,
   output logic [511:0]      core_block_o,
   output logic [6:0]        core_block_size_o,
   output logic              core_hash_size_o,
   input  state_t            core_state_i,
   input  logic [511:0]      core_hash_i,
   output logic              hash_valid_o,
   input  logic              hash_ready_i,
   output logic [511:0]      hash_o,
   output logic              busy_o
);

   localparam int GUARD_W = 8;

   sched_state_t       state_r, state_next_s;
   logic               s_ready_r, trg_r, hash_size_r, hash_valid_r, open_r;
   logic               final_r, pend_empty_r;
   logic [511:0]       block_r, hash_r;
   logic [6:0]         size_r;
   logic [GUARD_W-1:0] guard_r;
   logic               accept_s, core_ready_s, clr_s, close_s;
   logic [2:0]         pk_cnt_s;
   logic [511:0]       pk_block_s;
   logic [6:0]         pk_size_s;

   assign accept_s     = s_valid_i & s_ready_r;
   assign core_ready_s = (core_state_i == READY);
   // The current word completes a block when it is the last or fills slot 7.
   assign close_s      = s_last_i | (pk_cnt_s == 3'd7);
   // Packer is emptied whenever the core finishes a block.
   assign clr_s        = (state_r == WAIT) && (guard_r == '0) && core_ready_s;

   strhw_word_packer u_packer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_i       (accept_s),
      .clr_i      (clr_s),
      .data_i     (s_data_i),
      .last_i     (s_last_i),
      .bytes_i    (s_bytes_i),
      .word_cnt_o (pk_cnt_s),
      .block_o    (pk_block_s),
      .size_o     (pk_size_s)
   );

   // Next-state logic of the scheduler FSM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         FILL: begin
            if (accept_s && close_s) begin
               state_next_s = LAUNCH;
            end else begin
               state_next_s = FILL;
            end
         end
         LAUNCH: begin
            state_next_s = WAIT;
         end
         WAIT: begin
            if (guard_r != '0) begin
               state_next_s = WAIT;
            end else if (!core_ready_s) begin
               state_next_s = WAIT;
            end else if (pend_empty_r) begin
               state_next_s = LAUNCH;
            end else if (final_r) begin
               state_next_s = CAPTURE;
            end else begin
               state_next_s = FILL;
            end
         end
         CAPTURE: begin
            state_next_s = OUT;
         end
         OUT: begin
            if (hash_ready_i) begin
               state_next_s = FILL;
            end else begin
               state_next_s = OUT;
            end
         end
         default: begin
            state_next_s = FILL;
         end
      endcase
   end

   // FSM state, registered outputs and per-message bookkeeping.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r      <= FILL;
         s_ready_r    <= 1'b0;
         trg_r        <= 1'b0;
         block_r      <= 512'd0;
         size_r       <= 7'd0;
         hash_size_r  <= 1'b0;
         hash_valid_r <= 1'b0;
         hash_r       <= 512'd0;
         open_r       <= 1'b0;
         final_r      <= 1'b0;
         pend_empty_r <= 1'b0;
         guard_r      <= '0;
      end else begin
         state_r   <= state_next_s;
         s_ready_r <= (state_next_s == FILL);
         trg_r     <= (state_next_s == LAUNCH);
         if (accept_s && !open_r) begin
            hash_size_r <= hash_size_i;
         end
         case (state_r)
            FILL: begin
               if (accept_s) begin
                  open_r <= 1'b1;
                  if (close_s) begin
                     block_r      <= pk_block_s;
                     size_r       <= pk_size_s;
                     // A full final block still owes the core an empty block.
                     final_r      <= s_last_i && (pk_size_s != 7'(STRHW_BLOCK_BYTES));
                     pend_empty_r <= s_last_i && (pk_size_s == 7'(STRHW_BLOCK_BYTES));
                  end
               end
            end
            LAUNCH: begin
               guard_r <= GUARD_W'(GUARD_CYC);
            end
            WAIT: begin
               if (guard_r != '0) begin
                  guard_r <= guard_r - {{(GUARD_W-1){1'b0}}, 1'b1};
               end else if (core_ready_s && pend_empty_r) begin
                  block_r      <= 512'd0;
                  size_r       <= 7'd0;
                  final_r      <= 1'b1;
                  pend_empty_r <= 1'b0;
               end
            end
            CAPTURE: begin
               hash_r       <= core_hash_i;
               hash_valid_r <= 1'b1;
            end
            OUT: begin
               if (hash_ready_i) begin
                  hash_valid_r <= 1'b0;
                  open_r       <= 1'b0;
               end
            end
            default: begin
               open_r <= open_r;
            end
         endcase
      end
   end

   assign s_ready_o         = s_ready_r;
   assign core_trg_o        = trg_r;
   assign core_block_o      = block_r;
   assign core_block_size_o = size_r;
   assign core_hash_size_o  = hash_size_r;
   assign hash_valid_o      = hash_valid_r;
   assign hash_o            = hash_r;
   assign busy_o            = open_r;

endmodule

// File: doc/strhw_stream_sched.md
Name: strhw_stream_sched

Overview:
- Front-end scheduler for the Streebog hash core.
- Accepts a message as a stream of 64-bit words over a valid/ready handshake and packs the words into 512-bit blocks.
- Triggers the core once per block with the correct block size, including the mandatory final short or empty block.
- Captures the final hash and holds it for a downstream consumer. It sits between the bus/DMA side and the core's trg/state/block/hash interface.

Parameters:
WORD_W, 64, input word width in bits; fixed at 64 (8 bytes, 8 words per block).
GUARD_CYC, 1, cycles after core trigger during which core_state_i is ignored.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-low
s_valid_i  in  1  input word valid
s_ready_o  out  1  input word accepted when s_valid_i & s_ready_o
s_data_i  in  64  message word; byte 0 = bits [7:0]
s_last_i  in  1  final word of message
s_bytes_i  in  4  valid bytes in final word, 0..8; ignored when s_last_i=0
hash_size_i  in  1  0=512-bit, 1=256-bit; sampled on first accepted word of a message
core_trg_o  out  1  one-cycle start pulse to core
core_block_o  out  512  packed block
core_block_size_o  out  7  block size in bytes, 0..64
core_hash_size_o  out  1  latched hash size
core_state_i  in  state_t  core state (strhw_common_types::state_t)
core_hash_i  in  512  core hash result
hash_valid_o  out  1  hash available
hash_ready_i  in  1  hash consumed when hash_valid_o & hash_ready_i
hash_o  out  512  registered hash
busy_o  out  1  message in progress (any state but FILL with word_cnt=0 and no message open)

Behaviour:
- Reset (rst_i=0 at a clk_i edge) has priority over all other activity, including mid-block and mid-core-run. Reset values:
  - state=FILL, word_cnt=0, buffer=0.
  - s_ready_o=0 during reset, 1 on the first cycle after.
  - core_trg_o=0, core_block_o=0, core_block_size_o=0, core_hash_size_o=0.
  - hash_valid_o=0, hash_o=0, busy_o=0.
- Packing:
  - Accepted word k (0..7) writes buffer[64k+63:64k]; word_cnt increments.
  - On the last word, bytes at index >= s_bytes_i are zeroed.
  - Unfilled words of the block are 0.
- FSM states:
  - FILL: s_ready_o=1. A non-last accept with word_cnt=7 moves to LAUNCH with size=64 and final=0. A last accept moves to LAUNCH with size=8*word_cnt+s_bytes_i; final=1 if size<64. If size==64, final=0 and pend_empty=1.
  - LAUNCH: core_trg_o=1 for exactly one cycle. core_block_o and core_block_size_o are registered, stable from LAUNCH until the next LAUNCH. Next state is WAIT.
  - WAIT: s_ready_o=0. The first GUARD_CYC cycles ignore core_state_i; afterwards the FSM waits for core_state_i==READY. Then:
    - if pend_empty, load an all-zero block, size=0, final=1, clear pend_empty, go to LAUNCH;
    - else if final, go to CAPTURE;
    - else go to FILL with word_cnt=0.
  - CAPTURE: hash_o<=core_hash_i; hash_valid_o<=1; next state is OUT.
  - OUT: s_ready_o=0. On hash_ready_i, hash_valid_o<=0 and next state is FILL. The message is closed.
- Last-word boundary cases:
  - Empty message: a single last beat with s_bytes_i=0 at word_cnt=0 gives size 0, final=1, one core run.
  - s_bytes_i>8 is saturated to 8.
- core_hash_size_o is latched from hash_size_i on the first accepted word of each message and held to message end.
- No back-to-back overlap: s_ready_o=0 in LAUNCH, WAIT, CAPTURE, OUT.
- Throughput: 1 word/cycle during FILL. Block latency from 8th accept to trigger is 1 cycle.
- Counter width: word_cnt is 3 bits and wraps only via the explicit reset to 0 in WAIT.

Decomposition:
- Add to strhw_common_types:
  - sched_state_t enum {FILL, LAUNCH, WAIT, CAPTURE, OUT};
  - STRHW_BLOCK_BYTES=64;
  - STRHW_WORD_BYTES=8;
  - type uint64.
- One natural sub-module: strhw_word_packer, holding the buffer, word_cnt, byte masking and size computation.
- The FSM stays in strhw_stream_sched.

Test Plan:
- 1 last word, bytes=3, data 0x..._636261 ("abc") -> one trg, block_size=3, block bits[23:0]=0x636261 and the rest 0; hash_o equals the core's result, with hash_valid_o until ready.
- 8 full words then last word bytes=8 (72 bytes) -> two trgs, sizes 64 then 8; no third run.
- Exactly 8 words with the 8th last, bytes=8 (64 bytes) -> two trgs, sizes 64 then 0; the second block is all zero.
- Empty message (last, bytes=0) -> one trg, size 0; hash returned; hash_size=1 is propagated on core_hash_size_o.
- Core holds non-READY 20 cycles -> s_ready_o=0 and no second trg until READY; hash_ready_i held low 5 cycles -> hash_o stable, s_ready_o=0.
- rst_i=0 asserted in WAIT mid-message -> next cycle all outputs are at reset values; a following 3-byte message hashes correctly with size=3.
